sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
- Single-clock synchronous FIFO, depth 2**AWIDTH words of DWIDTH bits.
- Behaviour and flag timing are cycle-equivalent to the vendor single-clock FIFO (scfifo, overflow/underflow checking on), so either can be used interchangeably in the datapath.
- Supports show-ahead (first-word-fall-through) and normal registered-read modes.

Parameters:
- DWIDTH, 8, data word width in bits.
- AWIDTH, 4, address width; FIFO depth = 2**AWIDTH.
- SHOWAHEAD, "ON", string; "ON" = first-word-fall-through, "OFF" = normal read with one-cycle registered output.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  reset, synchronous, active-high.
- wrreq_i  in  1  write request.
- data_i  in  DWIDTH  write data, sampled when wrreq_i accepted.
- rdreq_i  in  1  read request (ack in show-ahead mode).
- q_o  out  DWIDTH  read data.
- empty_o  out  1  FIFO holds 0 words.
- full_o  out  1  FIFO holds 2**AWIDTH words.
- usedw_o  out  AWIDTH  stored word count, modulo 2**AWIDTH.

Behaviour:
- Reset:
  - Synchronous, active-high srst_i clears read pointer, write pointer and count.
  - Next edge after reset: empty_o=1, full_o=0, usedw_o=0, q_o=0.
  - Reset mid-operation discards all contents. Memory array itself is not cleared.
- Internal count:
  - cnt is AWIDTH+1 bits, range 0..2**AWIDTH.
  - usedw_o = cnt[AWIDTH-1:0], so a full FIFO reports usedw_o=0 with full_o=1.
- Acceptance:
  - wr_en = wrreq_i && !full_o.
  - rd_en = rdreq_i && !empty_o.
  - Write when full is ignored (no data or pointer change). Read when empty is ignored.
- Pointers and count update:
  - Write pointer advances on wr_en; read pointer advances on rd_en. Both wrap naturally at 2**AWIDTH.
  - cnt <= cnt + wr_en - rd_en.
- Simultaneous requests:
  - Full with both requests: only the read occurs; cnt decrements; full_o falls next cycle.
  - Empty with both requests: only the write occurs; cnt=1 next cycle.
  - Neither full nor empty with both requests: cnt unchanged, both pointers advance.
- Flags are registered, updated on the same edge as cnt (latency 1 clock from the accepted request):
  - empty_o <= (next cnt == 0).
  - full_o <= (next cnt == 2**AWIDTH).
- SHOWAHEAD="ON":
  - q_o presents mem[rd_ptr] whenever empty_o=0, i.e. from the cycle after the first write into an empty FIFO.
  - rdreq_i acknowledges that word; the next word appears the cycle after the read.
  - q_o is don't-care while empty_o=1.
- SHOWAHEAD="OFF":
  - On rd_en, q_o <= mem[rd_ptr], valid the cycle after rdreq_i.
  - q_o holds its value otherwise, including reads attempted while empty.
- Write-then-read of the same location in one cycle cannot occur: the FIFO is never both empty and full.
- Any other SHOWAHEAD value is illegal; elaboration error.

Decomposition:
- Package fifo_pkg holds:
  - the localparam for depth computation (2**AWIDTH);
  - the legal SHOWAHEAD string constants "ON" and "OFF".
- One sub-module, sync_fifo_ram: simple dual-port array.
  - Write port: synchronous.
  - Read port: combinational for show-ahead, registered for normal mode, selected by a parameter.
- Pointer, count and flag logic lives in the top module.

Test Plan (DWIDTH=8, AWIDTH=4):
1. Reset, then 16 consecutive writes of 0x00..0x0F:
   - usedw_o steps 1..15, then 0.
   - full_o=1 and empty_o=0 after the 16th edge.
   - A 17th write is ignored; usedw_o stays 0 and full_o stays 1.
2. From full, 16 consecutive reads:
   - Data returns 0x00..0x0F in order.
   - ON: q_o=0x00 before the first rdreq_i. OFF: q_o=0x00 the cycle after the first rdreq_i.
   - Ends with empty_o=1, usedw_o=0.
   - Extra read leaves flags unchanged and, in OFF mode, q_o holds 0x0F.
3. Simultaneous wrreq_i+rdreq_i:
   - With 5 words stored: usedw_o stays 5, order preserved.
   - When full: usedw_o becomes 15, full_o=0.
   - When empty: usedw_o becomes 1, empty_o=0.
4. Single write of 0xA5 into empty FIFO:
   - empty_o falls on the next edge.
   - ON mode: q_o=0xA5 in that cycle. One read returns empty_o=1 next cycle.
5. Fill to 10 words, then assert srst_i for one cycle mid-burst:
   - Next cycle: empty_o=1, full_o=0, usedw_o=0, q_o=0.
   - Subsequent write/read of 0x3C returns 0x3C.
6. Long random mix of idle/write/read/read-write (≥100 cycles, pointer wrap exercised):
   - empty_o, full_o, usedw_o match a reference count model every cycle.
   - Data order matches a scoreboard queue.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock FIFO.
// Depth helper and legal read-mode selectors.
package fifo_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int AWIDTH_DEF = 4;

  localparam string SA_ON  = "ON";
  localparam string SA_OFF = "OFF";

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo.
// Synchronous write; read is combinational or registered.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter bit REG_RD = 1'b0
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem [fifo_depth(AWIDTH)];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  generate
    if (REG_RD) begin : g_reg
      logic [DWIDTH-1:0] rdata_q;
      logic [DWIDTH-1:0] rdata_d;

      always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem[raddr_i];
      end

      always_ff @(posedge clk_i) begin
        if (srst_i) rdata_q <= '0;
        else        rdata_q <= rdata_d;
      end

      assign rdata_o = rdata_q;
    end else begin : g_comb
      logic unused_ok;
      assign unused_ok = ^{srst_i, re_i};
      assign rdata_o   = mem[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead or registered read.
// Pointers, count and registered flags; storage in sync_fifo_ram.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int    DWIDTH    = DWIDTH_DEF,
  parameter int    AWIDTH    = AWIDTH_DEF,
  parameter string SHOWAHEAD = SA_ON
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH-1:0] usedw_o
);

  localparam int DEPTH = fifo_depth(AWIDTH);
  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] CNT_ONE  = (AWIDTH+1)'(1);
  localparam logic [AWIDTH-1:0] PTR_ONE = AWIDTH'(1);
  localparam bit SHOW_ON  = (SHOWAHEAD == SA_ON);
  localparam bit SHOW_OFF = (SHOWAHEAD == SA_OFF);

  generate
    if (!(SHOW_ON || SHOW_OFF)) begin : g_bad_mode
      $error("sync_fifo: SHOWAHEAD must be \"ON\" or \"OFF\"");
    end
  endgenerate

  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              wr_en, rd_en;
  logic [DWIDTH-1:0] ram_rdata;

  always_comb begin
    wr_en    = wrreq_i && !full_q;
    rd_en    = rdreq_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en && !rd_en) cnt_d = cnt_q + CNT_ONE;
    if (!wr_en && rd_en) cnt_d = cnt_q - CNT_ONE;
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == FULL_CNT);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  sync_fifo_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .REG_RD (SHOW_OFF)
  ) u_ram (
    .clk_i   (clk_i),
    .srst_i  (srst_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_i),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Gate show-ahead output while empty so reset leaves q_o at zero.
  generate
    if (SHOW_OFF) begin : g_q_reg
      assign q_o = ram_rdata;
    end else begin : g_q_fwft
      assign q_o = empty_q ? '0 : ram_rdata;
    end
  endgenerate

  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign usedw_o = cnt_q[AWIDTH-1:0];

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: show-ahead and registered-read instances
// driven in lockstep and compared against a queue model.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          srst = 1'b0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [DW-1:0] data = '0;

  logic [DW-1:0] q_on, q_off;
  logic          empty_on, empty_off;
  logic          full_on, full_off;
  logic [AW-1:0] usedw_on, usedw_off;

  int n_chk  = 0;
  int n_pass = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_off = '0;

  always #5 clk = ~clk;

  sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("ON")) u_on (
    .clk_i   (clk),
    .srst_i  (srst),
    .wrreq_i (wrreq),
    .data_i  (data),
    .rdreq_i (rdreq),
    .q_o     (q_on),
    .empty_o (empty_on),
    .full_o  (full_on),
    .usedw_o (usedw_on)
  );

  sync_fifo #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD("OFF")) u_off (
    .clk_i   (clk),
    .srst_i  (srst),
    .wrreq_i (wrreq),
    .data_i  (data),
    .rdreq_i (rdreq),
    .q_o     (q_off),
    .empty_o (empty_off),
    .full_o  (full_off),
    .usedw_o (usedw_off)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic compare();
    int n;
    n = mq.size();
    chk("empty_on",  32'(empty_on),  32'(n == 0));
    chk("empty_off", 32'(empty_off), 32'(n == 0));
    chk("full_on",   32'(full_on),   32'(n == DEPTH));
    chk("full_off",  32'(full_off),  32'(n == DEPTH));
    chk("usedw_on",  32'(usedw_on),  32'(n % DEPTH));
    chk("usedw_off", 32'(usedw_off), 32'(n % DEPTH));
    if (n > 0) chk("q_on", 32'(q_on), 32'(mq[0]));
    chk("q_off", 32'(q_off), 32'(exp_off));
  endtask

  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit aw, ar;
    wrreq = w;
    rdreq = r;
    data  = d;
    @(posedge clk);
    aw = w && (mq.size() < DEPTH);
    ar = r && (mq.size() > 0);
    if (ar) exp_off = mq.pop_front();
    if (aw) mq.push_back(d);
    #1;
    compare();
    wrreq = 1'b0;
    rdreq = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic [DW-1:0] d);
    srst  = 1'b1;
    wrreq = w;
    data  = d;
    @(posedge clk);
    mq.delete();
    exp_off = '0;
    #1;
    compare();
    chk("rst_q_on", 32'(q_on), 32'h0);
    srst  = 1'b0;
    wrreq = 1'b0;
  endtask

  initial begin
    int wp;
    #2;
    do_reset(1'b0, '0);

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
    chk("t1_full", 32'(full_on), 32'h1);
    step(1'b1, 1'b0, 8'hEE);
    chk("t1_ovf_usedw", 32'(usedw_on), 32'h0);

    chk("t2_q_on_pre", 32'(q_on), 32'h00);
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    chk("t2_hold_off", 32'(q_off), 32'h0F);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, DW'($urandom));
    chk("t3_mid_usedw", 32'(usedw_on), 32'h5);
    while (mq.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b1, 8'h77);
    chk("t3_full_usedw", 32'(usedw_off), 32'd15);
    while (mq.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 8'h99);
    chk("t3_empty_usedw", 32'(usedw_on), 32'h1);
    step(1'b0, 1'b1, '0);

    step(1'b1, 1'b0, 8'hA5);
    chk("t4_q_on", 32'(q_on), 32'hA5);
    step(1'b0, 1'b1, '0);
    chk("t4_empty", 32'(empty_on), 32'h1);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, DW'($urandom));
    do_reset(1'b1, 8'h55);
    step(1'b1, 1'b0, 8'h3C);
    chk("t5_q_on", 32'(q_on), 32'h3C);
    step(1'b0, 1'b1, '0);
    chk("t5_q_off", 32'(q_off), 32'h3C);

    for (int i = 0; i < 600; i++) begin
      wp = ((i / 60) % 3 == 0) ? 75 : (((i / 60) % 3 == 1) ? 25 : 50);
      step(($urandom % 100) < wp, ($urandom % 100) < (100 - wp),
           DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
